// File: rtl/riscv_cpu_pkg.sv
// Core-wide parameters and shared types for the RISC-V CPU and its memory models.
package riscv_cpu_pkg;

  localparam int DATA_WIDTH         = 32;
  localparam int DMEM_WORDS_DEFAULT = 1024;

  typedef enum logic {
    DMEM_IDLE,
    DMEM_WAIT
  } dmem_state_t;

endpackage

// File: rtl/data_mem_responder_sp_ram_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module sp_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [DATA_WIDTH/8-1:0]  be,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Writes leave rdata untouched so the last read value stays on the port.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
          if (be[i]) begin
            mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: grants req after GNT_DELAY cycles, answers one cycle later
// from a byte-enabled RAM, and flags accesses beyond the RAM with err.
module data_mem_responder #(
  parameter int DATA_WIDTH = riscv_cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = riscv_cpu_pkg::DMEM_WORDS_DEFAULT,
  parameter int GNT_DELAY  = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o
);

  import riscv_cpu_pkg::*;

  localparam int                  IDX_W      = $clog2(MEM_WORDS);
  localparam logic [3:0]          CNT_LOAD   = (GNT_DELAY > 0) ? 4'(GNT_DELAY - 1) : 4'd0;
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS * 4);

  dmem_state_t           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  transfer;
  logic                  in_range;
  logic [IDX_W-1:0]      word_idx;
  logic                  ram_en;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  rvalid_q;
  logic                  err_q;
  logic                  rdata_sel_q;

  assign word_idx = data_addr_i[IDX_W+1:2];
  assign in_range = {1'b0, data_addr_i} < ADDR_LIMIT;
  assign transfer = data_req_i && data_gnt_o;
  assign ram_en   = transfer && in_range;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A request dropped while waiting abandons the wait without a grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE: begin
        if (data_req_i && (GNT_DELAY > 0)) begin
          state_d = DMEM_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      DMEM_WAIT: begin
        if (!data_req_i || (cnt_q == 4'd0)) begin
          state_d = DMEM_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  // Grant is forced low while reset is held so nothing is accepted in that window.
  always_comb begin
    data_gnt_o = 1'b0;
    case (state_q)
      DMEM_IDLE: data_gnt_o = (GNT_DELAY == 0) && data_req_i;
      DMEM_WAIT: data_gnt_o = data_req_i && (cnt_q == 4'd0);
    endcase
    if (!rst_ni) begin
      data_gnt_o = 1'b0;
    end
  end

  sp_ram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (MEM_WORDS)
  ) u_ram (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (data_we_i),
    .be    (data_be_i),
    .addr  (word_idx),
    .wdata (data_wdata_i),
    .rdata (ram_rdata)
  );

  // rdata_sel_q chooses the RAM output only for in-range reads; it and the RAM
  // port change only on a transfer, so rdata holds between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_sel_q <= 1'b0;
    end else begin
      rvalid_q <= transfer;
      if (transfer) begin
        err_q       <= !in_range;
        rdata_sel_q <= in_range && !data_we_i;
      end
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_sel_q ? ram_rdata : '0;

  req_held_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == DMEM_WAIT) |-> data_req_i);

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (slave) end of the core's data-memory req/gnt/rvalid interface; it answers the load/store initiator in the MEM stage.
- Holds a word-addressed, byte-enabled RAM and issues grants after a configurable wait.
- Returns exactly one rvalid per granted request, one cycle after the grant.
- Used as the data memory in simulation and FPGA builds; flags out-of-range accesses with an error.

Parameters:
- DATA_WIDTH, 32, data bus width; must equal riscv_cpu_pkg DATA_WIDTH.
- ADDR_WIDTH, 32, byte address width.
- MEM_WORDS, 1024, RAM depth in DATA_WIDTH words; power of two, at least 2.
- GNT_DELAY, 0, wait cycles between request assertion and grant (0..15).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  request valid from initiator.
- data_gnt_o  out  1  request accepted this cycle.
- data_addr_i  in  ADDR_WIDTH  byte address.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  DATA_WIDTH/8  byte enables for writes; initiators without byte enables tie this to all ones.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_rvalid_o  out  1  response valid.
- data_rdata_o  out  DATA_WIDTH  read data; qualified by rvalid.
- data_err_o  out  1  response error; qualified by rvalid.

Behaviour:
- Reset values: gnt 0, rvalid 0, rdata 0, err 0, FSM in IDLE, wait counter 0. RAM contents are not reset; the simulation model initialises them to 0.
- Reset mid-operation: outputs go to reset values immediately (asynchronous). A pending grant or response is dropped. No RAM write occurs in the reset cycle.
- Protocol: the initiator holds req, addr, we, be and wdata stable until gnt. A transfer happens in the cycle where req && gnt. rvalid is asserted exactly in the following cycle, for reads and writes alike.
- FSM states: IDLE, WAIT.
  - IDLE, GNT_DELAY = 0: gnt = req combinationally. The state stays IDLE.
  - IDLE, GNT_DELAY > 0, req = 1: go to WAIT, load cnt = GNT_DELAY-1, gnt = 0.
  - WAIT, cnt != 0: decrement cnt.
  - WAIT, cnt == 0: gnt = 1 this cycle, then return to IDLE.
  - WAIT, req drops (protocol violation): return to IDLE, clear cnt, no grant. Simulation-only assertion fires.
- Latency: req rising to gnt takes GNT_DELAY cycles; gnt to rvalid takes 1 cycle.
- Back-to-back: with GNT_DELAY = 0, a new request may be granted in the same cycle as the previous rvalid. One grant per cycle gives full throughput; there is at most one outstanding response.
- Address decode:
  - word index = addr[$clog2(MEM_WORDS)+1:2]; addr[1:0] ignored (the initiator aligns).
  - In range when addr < MEM_WORDS*4, otherwise out of range.
- Write, in range: on the grant edge, update only bytes with be[i] = 1. Response has rvalid = 1, rdata = 0, err = 0.
- Read, in range: rdata = RAM[index] registered on the grant edge; err = 0.
- Out of range: no RAM update. Response has rdata = 0, err = 1.
- Read after write to the same word in consecutive grants: the read returns the newly written data, because the write completes on the earlier edge.
- rdata holds its last value when rvalid = 0 (no bubble clearing), except after reset, where it is 0.

Decomposition:
- riscv_cpu_pkg: existing DATA_WIDTH. Add localparam DMEM_WORDS_DEFAULT = 1024 and a typedef enum logic {DMEM_IDLE, DMEM_WAIT} dmem_state_t.
- Sub-module sp_ram_be: single-port synchronous RAM with byte-write enables and registered read.
  - Ports: clk, en, we, be, addr, wdata, rdata.
  - The responder keeps the FSM, address decode, error path and rvalid/err registers.

Test Plan:
1. GNT_DELAY = 0: write addr 0x10, be 4'hF, wdata 0xDEADBEEF, then read 0x10.
   - Required: gnt in the same cycle as each req, rvalid the next cycle, read rdata 0xDEADBEEF, err 0.
2. Partial write: preload 0x20 = 0x11223344, write 0x20 with be 4'b0101 and wdata 0xAABBCCDD, then read.
   - Required: rdata 0x11BB33DD.
3. GNT_DELAY = 3: hold a read req at 0x10.
   - Required: gnt exactly 3 cycles after req rises, rvalid 1 cycle after gnt; rvalid occurs once only.
4. Out of range: read at addr 0x1000 (MEM_WORDS = 1024).
   - Required: rvalid 1, err 1, rdata 0.
   - A write to 0x1000 leaves word 0 unchanged.
5. Back-to-back: 4 consecutive reads at 0x0, 0x4, 0x8, 0xC with req held high.
   - Required: 4 grants in 4 cycles, 4 rvalids in the next 4 cycles, data in order.
6. Reset mid-transfer: with GNT_DELAY = 3, assert rst_ni = 0 during WAIT.
   - Required: gnt and rvalid 0 immediately and no response after reset release.
   - A fresh request after release is then granted with the full 3-cycle delay.
